photo_capture_sequencer: RTL and testbench

Session controller for the photobooth capture datapath. Once the selection UI has finished (filter and threshold chosen), it runs a multi-shot session: per-shot countdown, exactly one full camera frame written into the frame buffer, a start/done handshake with the filter pipeline, and a review hold. It sits between the selection screen, the camera frame-buffer write port and the filter pipeline, and latches the user's configuration so the pipeline sees stable settings for the whole session.

---
 rtl/photobooth_pkg.sv | 26 ++
 rtl/second_ticker.sv | 30 +++
 rtl/photo_capture_sequencer.sv | 156 +++++++++++++++
 tb/tb_photo_capture_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/photobooth_pkg.sv
// Shared types and constants for the photobooth capture path.
// Session FSM encoding, config field widths and filter codes.
package photobooth_pkg;

  localparam int FILTER_W = 3;
  localparam int THRESH_W = 2;

  localparam logic [FILTER_W-1:0] FILT_NONE   = 3'd0;
  localparam logic [FILTER_W-1:0] FILT_GRAY   = 3'd1;
  localparam logic [FILTER_W-1:0] FILT_SEPIA  = 3'd2;
  localparam logic [FILTER_W-1:0] FILT_INVERT = 3'd3;
  localparam logic [FILTER_W-1:0] FILT_EDGE   = 3'd4;
  localparam logic [FILTER_W-1:0] FILT_THRESH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_CAPTURE    = 3'd3,
    S_PROC_REQ   = 3'd4,
    S_PROC_WAIT  = 3'd5,
    S_REVIEW     = 3'd6,
    S_DONE       = 3'd7
  } seq_state_t;

endpackage

// File: rtl/second_ticker.sv
// Free-running divider producing one tick every CYCLES_PER_SEC cycles.
// Held at zero while clear_in is high, so the first tick follows a full period.
module second_ticker #(
  parameter int CYCLES_PER_SEC = 74_250_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W =
    (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clear_in || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_out = !clear_in && (cnt == LAST);

endmodule

// File: rtl/photo_capture_sequencer.sv
// Multi-shot photobooth session controller: countdown, one-frame
// capture window, filter pipeline handshake and review hold.
module photo_capture_sequencer
  import photobooth_pkg::*;
#(
  parameter int NUM_SHOTS      = 4,
  parameter int COUNT_SECS     = 3,
  parameter int CYCLES_PER_SEC = 74_250_000,
  parameter int REVIEW_FRAMES  = 60
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                arm_in,
  input  logic                shutter_in,
  input  logic                abort_in,
  input  logic                frame_start_in,
  input  logic [FILTER_W-1:0] filter_select_in,
  input  logic [THRESH_W-1:0] threshold_select_in,
  input  logic                proc_ready_in,
  input  logic                proc_done_in,
  output logic                capture_we_out,
  output logic                proc_start_out,
  output logic [FILTER_W-1:0] filter_cfg_out,
  output logic [THRESH_W-1:0] threshold_cfg_out,
  output logic [2:0]          countdown_out,
  output logic [2:0]          shot_index_out,
  output logic                busy_out,
  output logic                session_done_out
);

  localparam logic [2:0] CD_INIT   = 3'(COUNT_SECS);
  localparam logic [2:0] LAST_SHOT = 3'(NUM_SHOTS - 1);
  localparam logic [7:0] LAST_REV  = 8'(REVIEW_FRAMES - 1);

  seq_state_t          state, state_d;
  logic [2:0]          cd_d, shot_d;
  logic [FILTER_W-1:0] filt_d;
  logic [THRESH_W-1:0] thr_d;
  logic [7:0]          rev_cnt, rev_d;
  logic                shut_q, shut_edge;
  logic                tick;

  second_ticker #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_ticker (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clear_in(state != S_COUNTDOWN),
    .tick_out(tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shut_q    <= 1'b0;
      shut_edge <= 1'b0;
    end else begin
      shut_q    <= shutter_in;
      shut_edge <= shutter_in & ~shut_q;
    end
  end

  always_comb begin
    state_d = state;
    cd_d    = countdown_out;
    shot_d  = shot_index_out;
    filt_d  = filter_cfg_out;
    thr_d   = threshold_cfg_out;
    rev_d   = rev_cnt;
    if (abort_in) begin
      state_d = S_IDLE;
      cd_d    = '0;
      shot_d  = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (shut_edge && arm_in) begin
            filt_d  = filter_select_in;
            thr_d   = threshold_select_in;
            shot_d  = '0;
            cd_d    = CD_INIT;
            state_d = S_COUNTDOWN;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            cd_d = countdown_out - 3'd1;
            if (countdown_out == 3'd1) state_d = S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_start_in) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (frame_start_in) state_d = S_PROC_REQ;
        end
        S_PROC_REQ: begin
          if (proc_ready_in) state_d = S_PROC_WAIT;
        end
        S_PROC_WAIT: begin
          if (proc_done_in) begin
            rev_d   = '0;
            state_d = S_REVIEW;
          end
        end
        S_REVIEW: begin
          if (frame_start_in) begin
            rev_d = rev_cnt + 8'd1;
            if (rev_cnt == LAST_REV) begin
              if (shot_index_out == LAST_SHOT) begin
                state_d = S_DONE;
              end else begin
                shot_d  = shot_index_out + 3'd1;
                cd_d    = CD_INIT;
                state_d = S_COUNTDOWN;
              end
            end
          end
        end
        S_DONE: begin
          if (shut_edge) begin
            shot_d  = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_IDLE;
      rev_cnt           <= '0;
      countdown_out     <= '0;
      shot_index_out    <= '0;
      filter_cfg_out    <= '0;
      threshold_cfg_out <= '0;
      capture_we_out    <= 1'b0;
      proc_start_out    <= 1'b0;
      busy_out          <= 1'b0;
      session_done_out  <= 1'b0;
    end else begin
      state             <= state_d;
      rev_cnt           <= rev_d;
      countdown_out     <= cd_d;
      shot_index_out    <= shot_d;
      filter_cfg_out    <= filt_d;
      threshold_cfg_out <= thr_d;
      capture_we_out    <= (state_d == S_CAPTURE);
      proc_start_out    <= (state_d == S_PROC_REQ);
      busy_out          <= (state_d != S_IDLE) && (state_d != S_DONE);
      session_done_out  <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_photo_capture_sequencer.sv
// Directed bench for photo_capture_sequencer.
// Small timing parameters; frame_start every 50 cycles.
module tb_photo_capture_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       arm_in = 1'b0;
  logic       shutter_in = 1'b0;
  logic       abort_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic [2:0] filter_select_in = '0;
  logic [1:0] threshold_select_in = '0;
  logic       proc_ready_in = 1'b0;
  logic       proc_done_in = 1'b0;
  logic       capture_we_out;
  logic       proc_start_out;
  logic [2:0] filter_cfg_out;
  logic [1:0] threshold_cfg_out;
  logic [2:0] countdown_out;
  logic [2:0] shot_index_out;
  logic       busy_out;
  logic       session_done_out;

  int checks = 0;
  int errors = 0;
  int fc = 0;
  int n;

  photo_capture_sequencer #(
    .NUM_SHOTS     (2),
    .COUNT_SECS    (3),
    .CYCLES_PER_SEC(10),
    .REVIEW_FRAMES (2)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .arm_in             (arm_in),
    .shutter_in         (shutter_in),
    .abort_in           (abort_in),
    .frame_start_in     (frame_start_in),
    .filter_select_in   (filter_select_in),
    .threshold_select_in(threshold_select_in),
    .proc_ready_in      (proc_ready_in),
    .proc_done_in       (proc_done_in),
    .capture_we_out     (capture_we_out),
    .proc_start_out     (proc_start_out),
    .filter_cfg_out     (filter_cfg_out),
    .threshold_cfg_out  (threshold_cfg_out),
    .countdown_out      (countdown_out),
    .shot_index_out     (shot_index_out),
    .busy_out           (busy_out),
    .session_done_out   (session_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; frame_start pulses every 50th cycle.
  task automatic tick();
    @(negedge clk_in);
    fc = (fc == 49) ? 0 : fc + 1;
    frame_start_in = (fc == 49);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_cap_rise(input string tag);
    n = 0;
    while (!capture_we_out && n < 300) begin
      n++;
      tick();
    end
    chk(tag, capture_we_out, 1'b1);
  endtask

  task automatic count_cap(input string tag);
    n = 0;
    while (capture_we_out && n < 100) begin
      n++;
      tick();
    end
    chk(tag, n, 50);
  endtask

  task automatic count_cd(input string tag, input logic [2:0] v);
    n = 0;
    while (countdown_out == v && n < 100) begin
      n++;
      if (v == 3'd2 && n == 3) shutter_in = 1'b1;
      if (v == 3'd2 && n == 5) shutter_in = 1'b0;
      tick();
    end
    chk(tag, n, 10);
  endtask

  task automatic press();
    shutter_in = 1'b1;
    tick();
    shutter_in = 1'b0;
    tick();
  endtask

  initial begin
    ticks(3);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_cap", capture_we_out, 1'b0);
    chk("rst_pstart", proc_start_out, 1'b0);
    chk("rst_cd", countdown_out, 3'd0);
    chk("rst_done", session_done_out, 1'b0);
    chk("rst_filt", filter_cfg_out, 3'd0);
    rst_n_in = 1'b1;
    ticks(2);

    // shutter without arm
    filter_select_in = 3'd4;
    threshold_select_in = 2'd2;
    press();
    ticks(3);
    chk("noarm_busy", busy_out, 1'b0);
    chk("noarm_cd", countdown_out, 3'd0);

    // session start: two cycles from press to COUNTDOWN
    arm_in = 1'b1;
    shutter_in = 1'b1;
    tick();
    chk("edge_lat", countdown_out, 3'd0);
    tick();
    shutter_in = 1'b0;
    chk("cd_start", countdown_out, 3'd3);
    chk("busy_cd", busy_out, 1'b1);
    chk("filt_lat", filter_cfg_out, 3'd4);
    chk("thr_lat", threshold_cfg_out, 2'd2);
    chk("shot0", shot_index_out, 3'd0);
    arm_in = 1'b0;
    filter_select_in = 3'd1;
    count_cd("cd3_len", 3'd3);
    count_cd("cd2_len", 3'd2);
    count_cd("cd1_len", 3'd1);
    chk("cd_zero", countdown_out, 3'd0);
    chk("busy_wait", busy_out, 1'b1);

    wait_cap_rise("cap1_rise");
    chk("cap1_shot", shot_index_out, 3'd0);
    count_cap("cap1_len");
    chk("pstart_rise", proc_start_out, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("pstart_hold", proc_start_out, 1'b1);
      tick();
    end
    proc_ready_in = 1'b1;
    tick();
    proc_ready_in = 1'b0;
    chk("pstart_drop", proc_start_out, 1'b0);
    ticks(3);
    proc_done_in = 1'b1;
    tick();
    proc_done_in = 1'b0;
    chk("review_busy", busy_out, 1'b1);
    chk("review_cap", capture_we_out, 1'b0);

    n = 0;
    while (countdown_out != 3'd3 && n < 200) begin
      n++;
      tick();
    end
    chk("cd2_start", countdown_out, 3'd3);
    chk("shot1", shot_index_out, 3'd1);

    wait_cap_rise("cap2_rise");
    proc_ready_in = 1'b1;
    chk("cap2_shot", shot_index_out, 3'd1);
    count_cap("cap2_len");
    chk("pstart2_rise", proc_start_out, 1'b1);
    tick();
    proc_ready_in = 1'b0;
    chk("pstart2_drop", proc_start_out, 1'b0);
    proc_done_in = 1'b1;
    tick();
    proc_done_in = 1'b0;

    n = 0;
    while (!session_done_out && n < 200) begin
      n++;
      tick();
    end
    chk("done", session_done_out, 1'b1);
    chk("done_busy", busy_out, 1'b0);
    chk("done_filt", filter_cfg_out, 3'd4);
    chk("done_thr", threshold_cfg_out, 2'd2);
    chk("done_shot", shot_index_out, 3'd1);
    proc_done_in = 1'b1;
    tick();
    proc_done_in = 1'b0;
    tick();
    chk("done_hold", session_done_out, 1'b1);
    press();
    chk("idle_done", session_done_out, 1'b0);
    chk("idle_shot", shot_index_out, 3'd0);
    chk("idle_busy", busy_out, 1'b0);

    // abort coinciding with the frame_start that ends CAPTURE
    arm_in = 1'b1;
    filter_select_in = 3'd1;
    threshold_select_in = 2'd1;
    press();
    chk("s2_filt", filter_cfg_out, 3'd1);
    chk("s2_thr", threshold_cfg_out, 2'd1);
    wait_cap_rise("s2_cap_rise");
    n = 0;
    while (!frame_start_in && n < 100) begin
      n++;
      tick();
    end
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    chk("abort_cap", capture_we_out, 1'b0);
    chk("abort_pstart", proc_start_out, 1'b0);
    chk("abort_busy", busy_out, 1'b0);
    chk("abort_shot", shot_index_out, 3'd0);
    ticks(3);
    proc_done_in = 1'b1;
    tick();
    proc_done_in = 1'b0;
    ticks(2);
    chk("abort_done_ign", session_done_out, 1'b0);
    chk("abort_busy2", busy_out, 1'b0);
    chk("abort_pstart2", proc_start_out, 1'b0);

    // asynchronous reset in the middle of CAPTURE
    press();
    wait_cap_rise("s3_cap_rise");
    ticks(5);
    rst_n_in = 1'b0;
    #1;
    chk("arst_cap", capture_we_out, 1'b0);
    chk("arst_busy", busy_out, 1'b0);
    chk("arst_filt", filter_cfg_out, 3'd0);
    chk("arst_thr", threshold_cfg_out, 2'd0);
    chk("arst_shot", shot_index_out, 3'd0);
    ticks(3);
    rst_n_in = 1'b1;
    ticks(60);
    chk("post_rst_cap", capture_we_out, 1'b0);
    chk("post_rst_busy", busy_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
